// File: rtl/idx_symbol_packer_pkg.sv
// -----------------------------------------------------------------------------
// idx_symbol_packer_pkg
// Shared CSK constants and helpers used by the forward symbol mapper and the
// receive-side packer:
//   - bits-per-symbol computation from axis count and level count
//   - 2-bit Gray tables (forward and inverse) for 4-level axes
//   - legality test for a single base-4 index digit
//   - packer FSM state encoding
// -----------------------------------------------------------------------------
package idx_symbol_packer_pkg;

  localparam int IDX_W  = 6;   // three base-4 digits
  localparam int SYM_W  = 6;   // widest symbol (3 axes x 2 bits)
  localparam int BYTE_W = 8;
  localparam int ACC_W  = 14;  // up to 7 carried bits + 6 new bits
  localparam int CNT_W  = 3;   // 0..7 carried bits
  localparam int ERR_W  = 16;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pack_state_e;

  // Symbol bits per constellation point: 1 bit per 2-level axis, 2 per 4-level axis.
  function automatic int calc_bps(input int axis, input int levels);
    return axis * (levels >> 1);
  endfunction

  // Forward Gray map used by the transmitter: bits 00,01,11,10 -> level 0,1,2,3.
  function automatic logic [1:0] gray_enc4(input logic [1:0] bits);
    return {bits[1], bits[1] ^ bits[0]};
  endfunction

  // Inverse Gray map: level 0,1,2,3 -> bits 00,01,11,10.
  function automatic logic [1:0] gray_dec4(input logic [1:0] level);
    return {level[1], level[1] ^ level[0]};
  endfunction

  // A 2-level axis only uses the outer points 0 and 3; a 4-level axis uses all.
  function automatic logic digit_legal(input logic [1:0] level, input int levels);
    if (levels == 4) return 1'b1;
    return (level == 2'd0) || (level == 2'd3);
  endfunction

endpackage

// File: rtl/idx_symbol_packer_to_symbol.sv
// -----------------------------------------------------------------------------
// idx_to_symbol
// Combinational demapper: constellation index -> symbol bits plus illegal flag.
// Ports:
//   idx_in  [5:0]  base-4 digits d0=idx[1:0], d1=idx[3:2], d2=idx[5:4]
//   sym     [5:0]  demapped symbol, packed from bit 0 upward, unused bits 0
//   illegal        index is not a point of the configured constellation
// 4-level axis k lands in sym[2k+1:2k]; 2-level axis k lands in sym[k].
// Illegal 2-level digits (1,2) still decode to their nearer outer point via
// the MSB, so the data path never stalls on a bad index. Digits of axes that
// do not exist must be zero; nonzero ones are flagged and otherwise ignored.
// -----------------------------------------------------------------------------
module idx_to_symbol
  import idx_symbol_packer_pkg::*;
#(
  parameter int NUMBER_OF_AXIS   = 3,
  parameter int NUMBER_OF_LEVELS = 4
) (
  input  logic [IDX_W-1:0] idx_in,
  output logic [SYM_W-1:0] sym,
  output logic             illegal
);

  logic [1:0] digit;

  always_comb begin
    sym     = '0;
    illegal = 1'b0;
    digit   = '0;
    for (int k = 0; k < 3; k++) begin
      digit = idx_in[2*k +: 2];
      if (k < NUMBER_OF_AXIS) begin
        if (NUMBER_OF_LEVELS == 4) begin
          sym[2*k +: 2] = gray_dec4(digit);
        end else begin
          sym[k] = digit[1];
          if (!digit_legal(digit, NUMBER_OF_LEVELS)) illegal = 1'b1;
        end
      end else if (digit != 2'd0) begin
        illegal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/idx_symbol_packer.sv
// -----------------------------------------------------------------------------
// idx_symbol_packer
// Receive-side inverse of the CSK symbol mapper. Demaps constellation indices
// to symbol bits and packs them LSB-first into bytes; a frame's trailing
// partial byte is zero-padded and flushed with byte_last.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   idx_in/idx_valid/idx_last   index stream in, accepted when idx_ready
//   idx_ready                   packer can take idx_in this cycle
//   byte_out/byte_valid/byte_last  registered byte stream out
//   byte_ready                  consumer takes byte_out
//   sym_err                     one-cycle pulse after an illegal accepted index
//   err_count                   saturating count of illegal indices
//   state_dbg                   current FSM state
// Handshake: a beat moves when valid & ready are both high at a rising edge.
// The producer holds data stable while valid is high and ready is low; ready
// may depend combinationally on the downstream ready.
// -----------------------------------------------------------------------------
module idx_symbol_packer
  import idx_symbol_packer_pkg::*;
#(
  parameter int NUMBER_OF_AXIS   = 3,
  parameter int NUMBER_OF_LEVELS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic              idx_valid,
  input  logic              idx_last,
  output logic              idx_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              byte_last,
  input  logic              byte_ready,
  output logic              sym_err,
  output logic [ERR_W-1:0]  err_count,
  output pack_state_e       state_dbg
);

  localparam int         BPS   = calc_bps(NUMBER_OF_AXIS, NUMBER_OF_LEVELS);
  localparam logic [3:0] BPS_W = 4'(BPS);

  pack_state_e      state, state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic [SYM_W-1:0] sym;
  logic             illegal;
  logic [3:0]       cnt_sum;
  logic [ACC_W-1:0] combined;
  logic             slot_free;
  logic             accept;
  logic             fills_byte;
  logic             needs_flush;

  idx_to_symbol #(
    .NUMBER_OF_AXIS  (NUMBER_OF_AXIS),
    .NUMBER_OF_LEVELS(NUMBER_OF_LEVELS)
  ) u_demap (
    .idx_in (idx_in),
    .sym    (sym),
    .illegal(illegal)
  );

  // Bits above acc_cnt are always zero, so OR-ing in the shifted symbol is
  // the same as concatenating it above the carried bits.
  assign cnt_sum    = {1'b0, acc_cnt} + BPS_W;
  assign combined   = acc | (ACC_W'(sym) << acc_cnt);
  assign fills_byte = cnt_sum[3];
  assign slot_free  = ~byte_valid | byte_ready;
  // A symbol that does not complete a byte never touches the output slot,
  // so it may be taken even while the slot is blocked.
  assign idx_ready  = (state == ST_RUN) & (~fills_byte | slot_free);
  assign accept     = idx_valid & idx_ready;
  // Bits left over after this symbol; BPS >= 1 so a non-filling symbol
  // always leaves some.
  assign needs_flush = fills_byte ? (cnt_sum[2:0] != 3'd0) : 1'b1;
  assign state_dbg  = state;

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (accept && idx_last && needs_flush) state_next = ST_FLUSH;
      ST_FLUSH: if (slot_free) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      sym_err    <= 1'b0;
      err_count  <= '0;
      acc        <= '0;
      acc_cnt    <= '0;
    end else begin
      sym_err <= accept & illegal;
      if (accept && illegal && (err_count != '1)) err_count <= err_count + 1'b1;

      // Consumed byte frees the slot; a load below in the same cycle wins.
      if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
        byte_last  <= 1'b0;
      end

      if (state == ST_FLUSH) begin
        if (slot_free) begin
          byte_out   <= acc[BYTE_W-1:0];
          byte_valid <= 1'b1;
          byte_last  <= 1'b1;
          acc        <= '0;
          acc_cnt    <= '0;
        end
      end else if (accept) begin
        if (fills_byte) begin
          byte_out   <= combined[BYTE_W-1:0];
          byte_valid <= 1'b1;
          byte_last  <= idx_last & ~needs_flush;
          acc        <= combined >> BYTE_W;
          acc_cnt    <= cnt_sum[2:0];
        end else begin
          acc     <= combined;
          acc_cnt <= cnt_sum[2:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_idx_symbol_packer.sv
// -----------------------------------------------------------------------------
// tb_idx_symbol_packer
// Three packer instances (3 axes x 4 levels, 3 axes x 2 levels, 1 axis x 4
// levels) share one stimulus bus; sel routes idx_valid and the observed
// outputs to the instance under test. Expected bytes {last, data} are queued
// by the directed tests and popped by a monitor whenever a byte transfers.
// -----------------------------------------------------------------------------
module tb_idx_symbol_packer;
  import idx_symbol_packer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- stimulus bus ----------------
  logic [5:0] idx_in;
  logic       idx_valid, idx_last, byte_ready;
  logic [1:0] sel;

  logic        vld  [3];
  logic        rdy  [3];
  logic [7:0]  bo   [3];
  logic        bv   [3];
  logic        bl   [3];
  logic        se   [3];
  logic [15:0] ec   [3];
  pack_state_e st   [3];

  assign vld[0] = idx_valid && (sel == 2'd0);
  assign vld[1] = idx_valid && (sel == 2'd1);
  assign vld[2] = idx_valid && (sel == 2'd2);

  logic        m_ready, m_bv, m_bl, m_se;
  logic [7:0]  m_bo;
  pack_state_e m_st;
  assign m_ready = rdy[sel];
  assign m_bv    = bv[sel];
  assign m_bl    = bl[sel];
  assign m_bo    = bo[sel];
  assign m_se    = se[sel];
  assign m_st    = st[sel];

  idx_symbol_packer #(.NUMBER_OF_AXIS(3), .NUMBER_OF_LEVELS(4)) u_3x4 (
    .clk(clk), .reset(reset), .idx_in(idx_in), .idx_valid(vld[0]), .idx_last(idx_last),
    .idx_ready(rdy[0]), .byte_out(bo[0]), .byte_valid(bv[0]), .byte_last(bl[0]),
    .byte_ready(byte_ready), .sym_err(se[0]), .err_count(ec[0]), .state_dbg(st[0]));

  idx_symbol_packer #(.NUMBER_OF_AXIS(3), .NUMBER_OF_LEVELS(2)) u_3x2 (
    .clk(clk), .reset(reset), .idx_in(idx_in), .idx_valid(vld[1]), .idx_last(idx_last),
    .idx_ready(rdy[1]), .byte_out(bo[1]), .byte_valid(bv[1]), .byte_last(bl[1]),
    .byte_ready(byte_ready), .sym_err(se[1]), .err_count(ec[1]), .state_dbg(st[1]));

  idx_symbol_packer #(.NUMBER_OF_AXIS(1), .NUMBER_OF_LEVELS(4)) u_1x4 (
    .clk(clk), .reset(reset), .idx_in(idx_in), .idx_valid(vld[2]), .idx_last(idx_last),
    .idx_ready(rdy[2]), .byte_out(bo[2]), .byte_valid(bv[2]), .byte_last(bl[2]),
    .byte_ready(byte_ready), .sym_err(se[2]), .err_count(ec[2]), .state_dbg(st[2]));

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Pops on every transferred byte; while a byte waits, it must not change.
  task automatic monitor();
    logic       held_v;
    logic [8:0] held;
    logic [8:0] e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held_v = 1'b0;
      end else begin
        if (held_v) check("hold_stable", {23'd0, m_bv, m_bl, m_bo}, {23'd0, 1'b1, held});
        if (m_bv && byte_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {23'd0, m_bl, m_bo}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("byte", {23'd0, m_bl, m_bo}, {23'd0, e});
          end
          held_v = 1'b0;
        end else if (m_bv) begin
          held_v = 1'b1;
          held   = {m_bl, m_bo};
        end else begin
          held_v = 1'b0;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the index was accepted.
  task automatic send(input logic [5:0] v, input logic last, input logic ill);
    int n;
    idx_in    = v;
    idx_last  = last;
    idx_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (m_ready || n >= 50) break;
      n++;
    end
    if (n >= 50) begin
      check("send_timeout", 32'(n), 32'd0);
      idx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    idx_valid = 1'b0;
    idx_last  = 1'b0;
    check("sym_err", {31'd0, m_se}, {31'd0, ill});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic frame_basic();
    exp_q.push_back({1'b0, 8'h1E});
    exp_q.push_back({1'b1, 8'h00});
    send(6'd27, 1'b0, 1'b0);
    send(6'd0,  1'b1, 1'b0);
    check("t1_flush_state", 32'(m_st), 32'(ST_FLUSH));
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; idx_in = '0; idx_valid = 1'b0; idx_last = 1'b0;
    byte_ready = 1'b1; sel = 2'd0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_byte_out",  32'(bo[i]), 32'd0);
      check("rst_valid",     {31'd0, bv[i]}, 32'd0);
      check("rst_last",      {31'd0, bl[i]}, 32'd0);
      check("rst_sym_err",   {31'd0, se[i]}, 32'd0);
      check("rst_err_count", 32'(ec[i]), 32'd0);
      check("rst_ready",     {31'd0, rdy[i]}, 32'd1);
      check("rst_state",     32'(st[i]), 32'(ST_RUN));
    end
    @(posedge clk);
    #1;

    // 1: two symbols, remainder flushed
    frame_basic();

    // 2: four full symbols, last byte lands exactly on a boundary
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b0, 8'hAA});
    exp_q.push_back({1'b1, 8'hAA});
    for (int i = 0; i < 3; i++) send(6'd63, 1'b0, 1'b0);
    send(6'd63, 1'b1, 1'b0);
    check("t2_no_flush", 32'(m_st), 32'(ST_RUN));
    wait_drain();

    // 4: backpressure holds a byte and stalls the index side
    byte_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h1E});
    exp_q.push_back({1'b0, 8'hA0});
    exp_q.push_back({1'b1, 8'hAA});
    send(6'd27, 1'b0, 1'b0);
    send(6'd0,  1'b0, 1'b0);
    idx_in = 6'd63; idx_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_stall_ready", {31'd0, m_ready}, 32'd0);
      check("t4_stall_valid", {31'd0, m_bv}, 32'd1);
    end
    @(posedge clk);
    #1 idx_valid = 1'b0;
    byte_ready = 1'b1;
    send(6'd63, 1'b0, 1'b0);
    send(6'd63, 1'b1, 1'b0);
    wait_drain();

    // 5: single 4-level axis, partial byte via FLUSH
    sel = 2'd2;
    exp_q.push_back({1'b1, 8'h2D});
    send(6'd1, 1'b0, 1'b0);
    send(6'd2, 1'b0, 1'b0);
    send(6'd3, 1'b1, 1'b0);
    check("t5_flush_state", 32'(m_st), 32'(ST_FLUSH));
    wait_drain();
    // nonzero digits of absent axes are flagged and ignored
    exp_q.push_back({1'b1, 8'h01});
    send(6'h11, 1'b1, 1'b1);
    wait_drain();
    check("t5_err_count", 32'(ec[2]), 32'd1);

    // 3: 2-level axes, illegal middle point
    sel = 2'd1;
    exp_q.push_back({1'b1, 8'h07});
    send(6'd63, 1'b0, 1'b0);
    send(6'd1,  1'b1, 1'b1);
    wait_drain();
    check("t3_err_count", 32'(ec[1]), 32'd1);
    check("t3_other_err", 32'(ec[0]), 32'd0);

    // 6: reset mid-frame with a byte pending
    sel = 2'd0;
    byte_ready = 1'b0;
    send(6'd27, 1'b0, 1'b0);
    send(6'd27, 1'b0, 1'b0);
    check("t6_pending", {31'd0, m_bv}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_byte_out",  32'(m_bo), 32'd0);
    check("t6_valid",     {31'd0, m_bv}, 32'd0);
    check("t6_last",      {31'd0, m_bl}, 32'd0);
    check("t6_ready",     {31'd0, m_ready}, 32'd1);
    check("t6_err_count", 32'(ec[1]), 32'd0);
    @(posedge clk);
    #1 byte_ready = 1'b1;
    frame_basic();

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
